// File: rtl/vmx_pkg.sv
// ---------------------------------------------------------------------------
// vmx_pkg
// Shared constants and types for the VMX column-accumulator slice.
//   VMX_SUM_BITLEN  : width of a column partial sum coming out of the PE chain
//   VMX_ACC_BITLEN  : width of an accumulated result
//   VMX_LANE_BITLEN : width of one SIMD lane inside an accumulated result
//   acc_state_t     : accumulator FSM encoding
//   vmx_clamp_passes: maps a configured pass count of 0 onto 1
// ---------------------------------------------------------------------------
package vmx_pkg;

   localparam int VMX_SUM_BITLEN  = 32;
   localparam int VMX_ACC_BITLEN  = 48;
   localparam int VMX_LANE_BITLEN = VMX_ACC_BITLEN / 2;

   typedef enum logic {
      ACC_IDLE  = 1'b0,
      ACC_ACCUM = 1'b1
   } acc_state_t;

   // A result always needs at least one beat, so 0 is read as 1
   function automatic logic [7:0] vmx_clamp_passes(input logic [7:0] passes);
      return (passes == 8'd0) ? 8'd1 : passes;
   endfunction

endpackage

// File: rtl/vmx_result_fifo.sv
// ---------------------------------------------------------------------------
// vmx_result_fifo
// Small circular result FIFO with a valid/ready pop side.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored while full)
//   push_data  : entry to write
//   pop_ready  : consumer accepts the head entry
//   out_valid  : head entry valid
//   out_data   : head entry (read straight from storage, so it is registered)
//   full       : all DEPTH entries occupied
//   count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module vmx_result_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == (AW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // Full is judged on the registered count, so a pop in the same cycle
   // never makes room for a push
   assign do_push = push & ~full;
   assign do_pop  = out_valid & pop_ready;

   // Storage and pointers; pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/vmx_col_accumulator.sv
// ---------------------------------------------------------------------------
// vmx_col_accumulator
// Accumulates a configured number of partial-sum beats from one systolic
// column into a result, either as a single wide sum or as two independent
// SIMD lanes, and queues finished results toward the writeback DMA.
//   clk, rst      : clock, asynchronous active-high reset
//   cfg_passes    : beats per result (0 read as 1)
//   cfg_load      : latch cfg_passes, only honoured while idle
//   in_valid/in_ready, in_simd_mode, in_sum : partial-sum input stream
//   out_valid/out_ready, out_data, out_simd : result output stream
//   busy          : a result is part-way accumulated
//   err_mode      : sticky, a beat arrived with the wrong mode mid-result
// ---------------------------------------------------------------------------
module vmx_col_accumulator
   import vmx_pkg::*;
#(
   parameter int SUM_BITLEN = VMX_SUM_BITLEN,
   parameter int ACC_BITLEN = VMX_ACC_BITLEN,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            cfg_passes,
   input  logic                  cfg_load,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_simd_mode,
   input  logic [SUM_BITLEN-1:0] in_sum,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_BITLEN-1:0] out_data,
   output logic                  out_simd,
   output logic                  busy,
   output logic                  err_mode
);

   localparam int LANE     = ACC_BITLEN / 2;
   localparam int SUM_LANE = SUM_BITLEN / 2;
   localparam int CW       = $clog2(FIFO_DEPTH) + 1;

   acc_state_t            state;
   logic [ACC_BITLEN-1:0] acc;
   logic [7:0]            beat_cnt;
   logic [7:0]            passes_q;
   logic                  mode_q;
   logic                  err_q;

   logic                  accept;
   logic                  last_beat;
   logic                  op_mode;
   logic [ACC_BITLEN-1:0] base;
   logic [ACC_BITLEN-1:0] sum_next;
   logic [LANE-1:0]       lane_lo;
   logic [LANE-1:0]       lane_hi;

   logic                  fifo_push;
   logic [ACC_BITLEN:0]   fifo_out;
   logic                  fifo_full;
   logic [CW-1:0]         fifo_count;

   assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
   assign accept   = in_valid & in_ready;
   assign busy     = (state == ACC_ACCUM);
   assign err_mode = err_q;

   // The first beat of a result starts from zero using its own mode tag;
   // later beats add onto acc and are interpreted with the latched mode even
   // if the incoming tag disagrees
   always_comb begin
      base      = (state == ACC_IDLE) ? '0 : acc;
      op_mode   = (state == ACC_IDLE) ? in_simd_mode : mode_q;
      lane_lo   = base[LANE-1:0] + {{(LANE-SUM_LANE){1'b0}}, in_sum[SUM_LANE-1:0]};
      lane_hi   = base[ACC_BITLEN-1:LANE] + {{(LANE-SUM_LANE){1'b0}}, in_sum[SUM_BITLEN-1:SUM_LANE]};
      sum_next  = base + {{(ACC_BITLEN-SUM_BITLEN){1'b0}}, in_sum};
      if (op_mode) begin
         sum_next = {lane_hi, lane_lo};
      end
      last_beat = (state == ACC_IDLE) ? (passes_q == 8'd1)
                                      : (({1'b0, beat_cnt} + 9'd1) == {1'b0, passes_q});
   end

   // accept already implies room in the FIFO; the extra term keeps a push
   // from ever being attempted against a full queue
   assign fifo_push = accept & last_beat & ~fifo_full;

   // Accumulator FSM: IDLE takes the first beat of a result, ACCUM takes the
   // rest and hands the finished sum to the FIFO on the closing beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ACC_IDLE;
         acc      <= '0;
         beat_cnt <= '0;
         passes_q <= 8'd1;
         mode_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ACC_IDLE: begin
               if (cfg_load) begin
                  passes_q <= vmx_clamp_passes(cfg_passes);
               end
               if (accept) begin
                  mode_q <= in_simd_mode;
                  if (last_beat) begin
                     acc      <= '0;
                     beat_cnt <= '0;
                  end else begin
                     acc      <= sum_next;
                     beat_cnt <= 8'd1;
                     state    <= ACC_ACCUM;
                  end
               end
            end
            ACC_ACCUM: begin
               if (accept) begin
                  if (in_simd_mode != mode_q) begin
                     err_q <= 1'b1;
                  end
                  if (last_beat) begin
                     acc      <= '0;
                     beat_cnt <= '0;
                     state    <= ACC_IDLE;
                  end else begin
                     acc      <= sum_next;
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= ACC_IDLE;
         endcase
      end
   end

   vmx_result_fifo #(
      .WIDTH (ACC_BITLEN + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({op_mode, sum_next}),
      .pop_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (fifo_out),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign out_simd = fifo_out[ACC_BITLEN];
   assign out_data = fifo_out[ACC_BITLEN-1:0];

endmodule
